// File: rtl/rd_port_rr_arbiter_9.sv
// Round-robin arbiter feeding the 9-to-1 register-file read-address mux.
// Issues at most one registered grant per cycle and tracks it through the read latency.
module rd_port_rr_arbiter_9 #(
  parameter int WIDTH      = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8:0]           req,
  input  logic [9*WIDTH-1:0]   req_addr,
  input  logic                 hold,
  output logic [8:0]           port_rd_en,
  output logic [9*WIDTH-1:0]   port_rd_addr,
  output logic [8:0]           rd_data_vld,
  output logic                 busy
);

  localparam int N = 9;

  logic [N-1:0]       port_rd_en_reg;
  logic [N-1:0]       port_rd_en_next;
  logic [N*WIDTH-1:0] port_rd_addr_reg;
  logic [N*WIDTH-1:0] port_rd_addr_next;
  logic [3:0]         ptr_reg;
  logic [3:0]         ptr_next;
  logic [N-1:0]       eligible;
  logic [3:0]         win_idx;
  logic               win_found;
  logic               grant;
  logic [N-1:0]       pipe_reg [RD_LATENCY];
  logic [N-1:0]       pipe_any;

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("RD_LATENCY must be in 1..4");
    end
  endgenerate

  // The current winner is masked so a requester still holding req is not re-granted.
  assign eligible = req & ~port_rd_en_reg;

  always_comb begin
    logic [4:0] sum;
    logic [3:0] cand;
    sum       = '0;
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum  = {1'b0, ptr_reg} + 5'(k);
      cand = (sum >= 5'(N)) ? 4'(sum - 5'(N)) : sum[3:0];
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = win_found && !hold;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign port_rd_en_next[gi] = grant && (win_idx == 4'(gi));
      assign port_rd_addr_next[gi*WIDTH +: WIDTH] =
        port_rd_en_next[gi] ? req_addr[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    ptr_next = ptr_reg;
    if (grant) begin
      ptr_next = (win_idx == 4'(N-1)) ? 4'd0 : win_idx + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_rd_en_reg   <= '0;
      port_rd_addr_reg <= '0;
      ptr_reg          <= '0;
    end else begin
      port_rd_en_reg   <= port_rd_en_next;
      port_rd_addr_reg <= port_rd_addr_next;
      ptr_reg          <= ptr_next;
    end
  end

  // Latency pipe: one 9-bit grant vector per cycle of register-file read latency.
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) pipe_reg[gi] <= '0;
          else        pipe_reg[gi] <= port_rd_en_reg;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) pipe_reg[gi] <= '0;
          else        pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  always_comb begin
    pipe_any = '0;
    for (int s = 0; s < RD_LATENCY; s++) begin
      pipe_any = pipe_any | pipe_reg[s];
    end
  end

  assign port_rd_en   = port_rd_en_reg;
  assign port_rd_addr = port_rd_addr_reg;
  assign rd_data_vld  = pipe_reg[RD_LATENCY-1];
  assign busy         = (|port_rd_en_reg) | (|pipe_any);

endmodule

// File: doc/rd_port_rr_arbiter_9.md
Name: rd_port_rr_arbiter_9

Overview:
- Round-robin arbiter directly upstream of the 9-to-1 register-file read-address mux.
- Accepts up to 9 concurrent read requests per cycle from exec-side requesters and registers one winner per cycle.
- Drives a strictly one-hot (or all-zero) set of port read enables plus the winner's address, which feed the mux.
- Tracks each grant through the fixed register-file read latency and returns a per-requester data-valid strobe.

Parameters:
- WIDTH, 6: read address width per port.
- RD_LATENCY, 1: cycles from grant (enable asserted at mux) to read data valid at requesters; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  9  bit i = requester i wants a read; held high until granted.
- req_addr  input  9*WIDTH  requester i address in bits [i*WIDTH +: WIDTH].
- hold  input  1  when high, no new grant is issued this cycle (e.g. write-port priority).
- port_rd_en  output  9  registered one-hot grant; bit i feeds mux port i enable.
- port_rd_addr  output  9*WIDTH  registered; slot i = latched req_addr slot i when granted, else zero.
- rd_data_vld  output  9  one-hot; bit i high exactly RD_LATENCY cycles after port_rd_en[i].
- busy  output  1  high while any grant is in flight (port_rd_en or latency pipe non-zero).

Behaviour:
- Reset (async assert, sync deassert by the external reset controller):
  - port_rd_en=0, port_rd_addr=0, rd_data_vld=0, busy=0.
  - Priority pointer ptr=0; latency pipe cleared.
- Arbitration, combinational each cycle:
  - eligible = req & ~port_rd_en. The current winner is masked so a requester whose req has not yet dropped is not re-granted.
  - If hold=1 or eligible=0: next port_rd_en=0.
  - Otherwise winner = first set bit of eligible scanning ptr, ptr+1, …, 8, 0, …, ptr-1 (mod 9).
- Register update on the clock edge:
  - port_rd_en <= onehot(winner) or 0.
  - port_rd_addr slot winner <= req_addr slot winner; all other slots <= 0.
  - ptr <= (winner+1) mod 9 when a grant is issued; ptr is unchanged otherwise. Wrap: winner 8 -> ptr 0.
- Grant latency: req sampled in cycle t -> port_rd_en in cycle t+1.
  - The requester sees its grant at t+1 and must drop req by t+2.
  - A req still high at t+1 is ignored via the mask. A req still high at t+2 is treated as a new request.
- Invariant: port_rd_en has popcount <= 1 every cycle, so the downstream mux never hits its default (X) case.
- Latency pipe: RD_LATENCY-deep shift register of 9-bit vectors.
  - Stage 0 <= port_rd_en; rd_data_vld = last stage.
  - Back-to-back grants produce back-to-back valids in the same order.
- busy = |port_rd_en | (OR of all pipe stages).
- hold asserted mid-stream: grants already issued still complete through the pipe; only new grants are suppressed; ptr frozen.
- Requests dropped before grant are simply lost; there is no internal queue.
- Reset mid-operation clears the pipe. In-flight rd_data_vld strobes are discarded and requesters must re-request.
- Single requester continuously high: granted every other cycle (mask effect), i.e. 50% throughput per requester. Multiple requesters achieve one grant per cycle.

Test Plan:
- Reset, then req=9'h004 with slot2 addr=6'h15 -> cycle+1: port_rd_en=9'h004, port_rd_addr slot2=6'h15, other slots 0; cycle+2 (RD_LATENCY=1): rd_data_vld=9'h004; busy high for 2 cycles.
- Fairness: req=9'h1FF held with each requester dropping its req the cycle after its grant, ptr=0 -> grants 0,1,2,…,8 on consecutive cycles; no gaps, no repeats.
- Wrap: ptr=8 (after granting 7), req=9'h101 -> grant 8 first, then 0; ptr ends at 1.
- hold: req=9'h030, hold=1 for 3 cycles -> port_rd_en=0 for those cycles, ptr unchanged; hold=0 -> grant 4, then 5 next cycle.
- Latency: RD_LATENCY=3, grants to 1,2,3 back-to-back -> rd_data_vld=9'h002, 9'h004, 9'h008 three cycles later on consecutive cycles; busy drops the cycle after the last valid.
- Reset mid-flight: assert rst_n=0 one cycle after a grant to port 6 -> all outputs 0 immediately (async); no rd_data_vld for port 6 after release; ptr=0.
